// File: rtl/rom_defs.sv
// ROM map constants and boot-loader state encoding shared by the loader and its packer.
// Latency: none (constants and a pure address helper).
// Backpressure: n/a.
package rom_defs;

    localparam logic [31:0] ROM_BASE_ADDR  = 32'h0800_0000;
    localparam logic [31:0] ROM_SIZE_BYTES = 32'h0010_0000;
    localparam logic [31:0] ROM_WORDS      = ROM_SIZE_BYTES >> 2;

    localparam logic [2:0] LD_IDLE    = 3'd0;
    localparam logic [2:0] LD_COLLECT = 3'd1;
    localparam logic [2:0] LD_WRITE   = 3'd2;
    localparam logic [2:0] LD_READ    = 3'd3;
    localparam logic [2:0] LD_CHECK   = 3'd4;
    localparam logic [2:0] LD_DONE    = 3'd5;
    localparam logic [2:0] LD_ERROR   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE    = LD_IDLE,
        S_COLLECT = LD_COLLECT,
        S_WRITE   = LD_WRITE,
        S_READ    = LD_READ,
        S_CHECK   = LD_CHECK,
        S_DONE    = LD_DONE,
        S_ERROR   = LD_ERROR
    } ld_state_t;

    // Byte address of 32-bit word number idx.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [18:0] idx);
        return base + {11'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four stream bytes into one little-endian 32-bit word (first byte in bits [7:0]).
// Latency: word_dat updates at the edge accepting the 4th byte; word_vld flags that byte combinationally.
// Backpressure: bytes move only when byte_vld && byte_rdy; the completed word holds until the next 4th byte.
module byte_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [7:0]  byte_dat,
    input  logic        byte_vld,
    input  logic        byte_rdy,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  byte_cnt;
    logic [23:0] partial;
    logic        accept;

    assign accept   = byte_vld && byte_rdy;
    assign word_vld = accept && (byte_cnt == 2'd3);

    // Partial bytes live apart from word_dat so the presented word stays stable while the next one fills.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
            word_dat <= 32'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            partial  <= 24'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
                2'd0:    partial[7:0]   <= byte_dat;
                2'd1:    partial[15:8]  <= byte_dat;
                2'd2:    partial[23:16] <= byte_dat;
                default: word_dat       <= {byte_dat, partial};
            endcase
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: packs host bytes into words and writes them sequentially into ROM (ROM_LOADER_VERIFY_EN adds readback compare).
// Latency: 5 cycles/word minimum (7 with readback); done one cycle after the last write (or check).
// Backpressure: byte_ready only in COLLECT; the stream stalls during write/readback and while idle.
module rom_loader
    import rom_defs::*;
#(
    parameter logic [31:0] BASE_ADDR = ROM_BASE_ADDR,
    parameter logic [31:0] ROM_BYTES = ROM_SIZE_BYTES
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [18:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        rom_write_enable,
    output logic [31:0] rom_address,
    output logic [31:0] rom_data_out,
    input  logic [31:0] rom_data_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] error_addr
);

    localparam logic [31:0] NUM_WORDS = ROM_BYTES >> 2;
    localparam logic [31:0] END_ADDR  = BASE_ADDR + ROM_BYTES;

    ld_state_t   state, state_nxt;
    logic [18:0] wc_q;
    logic [18:0] index_q;
    logic [31:0] addr_q;
    logic        err_q;
    logic [31:0] err_addr_q;
    logic        start_ok;
    logic        advance;
    logic        last_word;
    logic        word_vld;
    logic [31:0] word;

    assign start_ok  = (state == S_IDLE) && start;
    assign last_word = (index_q + 19'd1) == wc_q;

    byte_packer u_packer (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (start_ok),
        .byte_dat (byte_in),
        .byte_vld (byte_valid),
        .byte_rdy (byte_ready),
        .word_vld (word_vld),
        .word_dat (word)
    );

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == 19'd0)
                        state_nxt = S_DONE;
                    else if ({13'd0, word_count} > NUM_WORDS)
                        state_nxt = S_ERROR;
                    else
                        state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (word_vld)
                    state_nxt = S_WRITE;
            end
`ifdef ROM_LOADER_VERIFY_EN
            S_WRITE: state_nxt = S_READ;
            S_READ:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (rom_data_in != word) begin
                    state_nxt = S_ERROR;
                end else begin
                    advance   = 1'b1;
                    state_nxt = last_word ? S_DONE : S_COLLECT;
                end
            end
`else
            S_WRITE: begin
                advance   = 1'b1;
                state_nxt = last_word ? S_DONE : S_COLLECT;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            S_ERROR: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign byte_ready       = (state == S_COLLECT);
    assign busy             = state inside {S_COLLECT, S_WRITE, S_READ, S_CHECK};
    assign rom_write_enable = (state == S_WRITE);
    assign done             = (state == S_DONE);
    assign rom_address      = addr_q;
    assign rom_data_out     = word;
    assign error            = err_q;
    assign error_addr       = err_addr_q;

`ifndef ROM_LOADER_VERIFY_EN
    logic unused_rom_data;
    assign unused_rom_data = ^rom_data_in;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wc_q       <= 19'd0;
            index_q    <= 19'd0;
            addr_q     <= 32'd0;
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                wc_q       <= word_count;
                index_q    <= 19'd0;
                err_q      <= 1'b0;
                err_addr_q <= 32'd0;
            end
            // Address is captured with the completed word so both are stable for the whole write.
            if (word_vld)
                addr_q <= word_addr(BASE_ADDR, index_q);
            if (advance)
                index_q <= index_q + 19'd1;
            // Entering ERROR from IDLE is a range fault; from CHECK it is a readback mismatch.
            if (state_nxt == S_ERROR && state != S_ERROR) begin
                err_q      <= 1'b1;
                err_addr_q <= (state == S_IDLE) ? END_ADDR : addr_q;
            end
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a ROM model and a queue-based write reference.
module tb_rom_loader;

    localparam logic [31:0] BASE     = 32'h0800_0000;
    localparam logic [31:0] TB_BYTES = 32'h0000_0200;
    localparam int          TB_WORDS = 128;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [18:0] word_count = 19'd0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        rom_write_enable;
    logic [31:0] rom_address;
    logic [31:0] rom_data_out;
    logic [31:0] rom_data_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] error_addr;

    int          checks = 0;
    int          errors = 0;
    int          oor_writes = 0;
    logic [31:0] mem [TB_WORDS];
    logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    rom_loader #(.BASE_ADDR(BASE), .ROM_BYTES(TB_BYTES)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .word_count       (word_count),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .rom_write_enable (rom_write_enable),
        .rom_address      (rom_address),
        .rom_data_out     (rom_data_out),
        .rom_data_in      (rom_data_in),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .error_addr       (error_addr)
    );

    always #5 clock = ~clock;

    function automatic bit in_rom(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + TB_BYTES);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // ROM: write on the enabled edge, registered read; corrupt_addr flips one data bit on readback.
    always @(posedge clock) begin
        if (rom_write_enable && in_rom(rom_address))
            mem[widx(rom_address)] <= rom_data_out;
        if (in_rom(rom_address))
            rom_data_in <= mem[widx(rom_address)] ^ ((rom_address == corrupt_addr) ? 32'h0000_0100 : 32'h0);
        else
            rom_data_in <= 32'h0;
    end

    always @(negedge clock) begin
        if (rom_write_enable === 1'b1) begin
            wr_addr_q.push_back(rom_address);
            wr_data_q.push_back(rom_data_out);
            if (!in_rom(rom_address))
                oor_writes++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic pulse_start(input logic [18:0] wc);
        start = 1'b1;
        word_count = wc;
        step();
        start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_we"}, {31'd0, rom_write_enable}, 32'd0);
        check({tag, "_addr"}, rom_address, 32'd0);
        check({tag, "_wdata"}, rom_data_out, 32'd0);
        check({tag, "_error_addr"}, error_addr, 32'd0);
    endtask

    // One byte handshake; optional idle gap first, optional start pulse held while busy.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit poke);
        int n;
        if (gap) begin
            byte_valid = 1'b0;
            step();
        end
        byte_valid = 1'b1;
        byte_in = b;
        if (poke) begin
            start = 1'b1;
            word_count = 19'd1;
        end
        n = 0;
        while (byte_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("byte_ready", {31'd0, byte_ready}, 32'd1);
        step();
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic finish_load(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        step();
        check({tag, "_done_drop"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
        check({tag, "_write_count"}, 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
        for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_addr[%0d]", tag, i), wr_addr_q[i], exp_addr_q[i]);
            check($sformatf("%s_data[%0d]", tag, i), wr_data_q[i], exp_data_q[i]);
        end
    endtask

    // Random bytes; reference word is b0 + 256*b1 + 65536*b2 + 16777216*b3 at BASE + 4*w.
    task automatic send_words(input int n, input bit gaps, input bit poke);
        logic [7:0]  bt;
        logic [31:0] v;
        logic [31:0] mult;
        for (int w = 0; w < n; w++) begin
            v = 32'd0;
            mult = 32'd1;
            for (int k = 0; k < 4; k++) begin
                bt = 8'($urandom_range(0, 255));
                v = v + 32'(bt) * mult;
                mult = mult * 32'd256;
                send_byte(bt, gaps && (k % 2 == 1), poke && (k == 2));
            end
            exp_addr_q.push_back(BASE + 32'(4 * w));
            exp_data_q.push_back(v);
        end
    endtask

    task automatic load_words(input string tag, input int n, input bit gaps, input bit poke);
        clear_logs();
        pulse_start(19'(n));
        send_words(n, gaps, poke);
        finish_load(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // Directed little-endian word
        clear_logs();
        pulse_start(19'd1);
        send_byte(8'h67, 1'b0, 1'b0);
        send_byte(8'h45, 1'b0, 1'b0);
        send_byte(8'h23, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        exp_addr_q.push_back(32'h0800_0000);
        exp_data_q.push_back(32'h0123_4567);
        finish_load("single");

        load_words("rand3", 3, 1'b0, 1'b0);
        load_words("gaps_starts", 4, 1'b1, 1'b1);

        // Whole (reduced) ROM: last write lands on the final word, nothing beyond.
        load_words("full", TB_WORDS, 1'b0, 1'b0);
        check("full_last_addr", wr_addr_q[wr_addr_q.size() - 1], BASE + TB_BYTES - 32'd4);
        check("full_oor_writes", 32'(oor_writes), 32'd0);

        // Range rejection
        clear_logs();
        pulse_start(19'(TB_WORDS + 1));
        check("range_error", {31'd0, error}, 32'd1);
        check("range_error_addr", error_addr, BASE + TB_BYTES);
        check("range_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        check("range_sticky", {31'd0, error}, 32'd1);
        check("range_idle_ready", {31'd0, byte_ready}, 32'd0);
        pulse_start(19'd262145);
        check("range_big_error", {31'd0, error}, 32'd1);
        check("range_big_error_addr", error_addr, BASE + TB_BYTES);
        step();
        step();
        check("range_no_writes", 32'(wr_addr_q.size()), 32'd0);

        // Zero-length load completes immediately and clears the sticky error.
        pulse_start(19'd0);
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_error_clear", {31'd0, error}, 32'd0);
        check("zero_error_addr_clear", error_addr, 32'd0);
        step();
        check("zero_done_drop", {31'd0, done}, 32'd0);
        check("zero_no_writes", 32'(wr_addr_q.size()), 32'd0);

`ifdef ROM_LOADER_VERIFY_EN
        begin
            int n;
            clear_logs();
            corrupt_addr = BASE + 32'd8;
            pulse_start(19'd5);
            send_words(3, 1'b0, 1'b0);
            n = 0;
            while (error !== 1'b1 && n < 30) begin
                step();
                n++;
            end
            check("verify_error", {31'd0, error}, 32'd1);
            check("verify_error_addr", error_addr, BASE + 32'd8);
            repeat (10) step();
            check("verify_write_count", 32'(wr_addr_q.size()), 32'd3);
            check("verify_busy", {31'd0, busy}, 32'd0);
            check("verify_ready", {31'd0, byte_ready}, 32'd0);
            corrupt_addr = 32'hFFFF_FFFF;
        end
`endif

        // Reset mid-word: the partial bytes must not reach the next word.
        clear_logs();
        pulse_start(19'd2);
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'hBB, 1'b0, 1'b0);
        reset_n = 1'b0;
        step();
        check_all_zero("midreset");
        reset_n = 1'b1;
        step();
        check("midreset_no_writes", 32'(wr_addr_q.size()), 32'd0);
        load_words("after_reset", 1, 1'b0, 1'b0);

        check("final_oor_writes", 32'(oor_writes), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
